case_2_mul_share_arb: RTL and testbench
=======================================

Name: case_2_mul_share_arb

Overview:
- Shares one signed 11x8 -> 11-bit multiplier between NUM_REQ requesters.
- Round-robin arbitration, fixed 2-cycle pipeline, and a result bus tagged with the requester index.
- Sits between HLS-generated loop bodies and a single multiplier instance to save DSPs.
- Stalls the whole pipeline with ap_ce.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- ID_W, 2, width of the requester index (clog2(NUM_REQ), min 1).
- DIN0_W, 11, width of operand A (signed).
- DIN1_W, 8, width of operand B (signed).
- DOUT_W, 11, width of the result (signed).

Ports:
- ap_clk  in  1  clock, rising edge.
- ap_rst  in  1  asynchronous active-high reset.
- ap_ce  in  1  clock enable; when 0 the pipeline holds and no grants are issued.
- req_valid  in  NUM_REQ  per-requester request valid.
- req_ready  out  NUM_REQ  per-requester grant, one-hot or zero.
- req_din0  in  NUM_REQ*DIN0_W  packed operand A; requester i occupies slice i.
- req_din1  in  NUM_REQ*DIN1_W  packed operand B.
- res_vld  out  1  result valid, single-cycle pulse per result.
- res_id  out  ID_W  index of the requester that owns res_dout.
- res_dout  out  DOUT_W  product.
- busy  out  1  high when either pipeline stage holds a valid entry.

Behaviour:
- Reset (async assert, released synchronously to ap_clk):
  - rr_ptr=0, s1_vld=0, s2_vld=0.
  - res_vld=0, res_id=0, res_dout=0, busy=0.
- Arbitration (combinational):
  - Search order starts at rr_ptr and wraps modulo NUM_REQ.
  - The first i with req_valid[i]=1 gets req_ready[i]=1, but only if ap_ce=1.
  - req_ready is all zeros when ap_ce=0 or no request is valid.
- Handshake: a transfer occurs when req_valid[i] and req_ready[i] are both 1 at a clock edge.
  - Requester i must hold req_valid and its operands until it is granted.
  - A requester may drop valid at any time; no transfer then occurs.
- Pointer update on transfer: rr_ptr <= (granted index + 1) mod NUM_REQ. No transfer leaves rr_ptr unchanged.
- Stage 1 (on transfer, with ap_ce=1):
  - s1_a, s1_b, s1_id <= granted operands and index; s1_vld <= 1.
  - With ap_ce=1 and no transfer, s1_vld <= 0.
- Stage 2 (with ap_ce=1):
  - p = $signed(s1_a) * $signed(s1_b), full 19-bit product.
  - res_dout <= p[DOUT_W-1:0], i.e. two's-complement truncation.
  - res_id <= s1_id; res_vld <= s1_vld.
- Latency and throughput:
  - Transfer at edge N gives res_vld=1 in the cycle after edge N+1.
  - Throughput is 1 result per enabled cycle.
- ap_ce=0: every register holds, including res_vld.
  - A pending res_vld therefore stays high while ap_ce=0.
  - Consumers qualify res_vld with ap_ce.
- busy = s1_vld | s2_vld, where s2_vld is the res_vld register.
- No result backpressure; consumers must always accept results.
- Reset mid-operation discards in-flight entries with no output pulse; rr_ptr returns to 0.
- Fairness:
  - With all requesters continuously valid, grants follow 0,1,2,3,0,...
  - No requester waits more than NUM_REQ-1 transfers.

Optional Feature:
- Macro: CASE_2_MUL_SAT_EN.
- Defined: stage 2 saturates the 19-bit product to the signed DOUT_W range.
  - p > 1023 -> 1023; p < -1024 -> -1024; otherwise p.
  - Adds output sat_flag (1 bit), registered alongside res_vld; it is 1 when clamping occurred and resets to 0.
- Undefined: plain truncation; no sat_flag port.

Test Plan:
1. Reset then a single request:
   - Stimulus: req_valid=0001, din0=100, din1=-3.
   - Required: req_ready=0001 on the first cycle; 2 cycles later res_vld=1, res_id=0, res_dout=-300; busy high for exactly 2 cycles.
2. All four requesters valid continuously for 8 cycles:
   - Grant order 0,1,2,3,0,1,2,3.
   - res_id sequence identical, lagging by 2 cycles; back-to-back res_vld.
3. Round-robin skip:
   - Stimulus: rr_ptr=1 after a grant to 0; req_valid=1001.
   - Required: grant 3, then 0.
4. ap_ce low:
   - Stimulus: ap_ce=0 for 3 cycles while req_valid=1111 with one entry in each stage.
   - Required: req_ready=0000; res_vld, res_id and res_dout are frozen; the pipeline resumes in order after ap_ce=1.
5. Overflow, 1000 * 100 = 100000:
   - Without the macro: res_dout = 100000 mod 2048 as signed 11-bit = 1696 -> -352.
   - With CASE_2_MUL_SAT_EN: res_dout=1023, sat_flag=1.
   - Also -1024 * 127 -> -1024 with sat_flag=1 (macro build).
6. Reset mid-operation:
   - Stimulus: assert ap_rst asynchronously, mid-cycle, while s1 and s2 are both valid.
   - Required: res_vld=0 and busy=0 immediately; no result pulse after release; the next grant goes to requester 0 when all are valid.

Source files
------------

// File: rtl/case_2_mul_share_arb.sv
// case_2_mul_share_arb: round-robin front end sharing one signed 11x8 multiplier, 2-cycle pipeline, ap_ce stall.
// Optional macro CASE_2_MUL_SAT_EN: saturate instead of truncate and add sat_flag output.
`default_nettype none

module case_2_mul_share_arb #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2,
  parameter int DIN0_W  = 11,
  parameter int DIN1_W  = 8,
  parameter int DOUT_W  = 11
) (
  input  logic                      ap_clk,
  input  logic                      ap_rst,
  input  logic                      ap_ce,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*DIN0_W-1:0] req_din0,
  input  logic [NUM_REQ*DIN1_W-1:0] req_din1,
  output logic                      res_vld,
  output logic [ID_W-1:0]           res_id,
  output logic [DOUT_W-1:0]         res_dout,
`ifdef CASE_2_MUL_SAT_EN
  output logic                      sat_flag,
`endif
  output logic                      busy
);

  localparam int PROD_W = DIN0_W + DIN1_W;
  localparam logic [ID_W-1:0] LAST_ID = ID_W'(NUM_REQ - 1);
  localparam logic [ID_W:0]   NUM_REQ_W = (ID_W+1)'(NUM_REQ);

  logic [ID_W-1:0]   rr_ptr;
  logic [NUM_REQ-1:0] grant;
  logic [ID_W-1:0]   grant_idx;
  logic [ID_W:0]     cand;
  logic              xfer;

  logic              s1_vld;
  logic [ID_W-1:0]   s1_id;
  logic [DIN0_W-1:0] s1_a;
  logic [DIN1_W-1:0] s1_b;
  logic [PROD_W-1:0] prod;
  logic [DOUT_W-1:0] dout_next;

  // Rotating priority search: first valid requester at or after rr_ptr wins.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    cand      = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = {1'b0, rr_ptr} + (ID_W+1)'(k);
      if (cand >= NUM_REQ_W) begin
        cand = cand - NUM_REQ_W;
      end
      if (ap_ce && (grant == '0) && req_valid[cand[ID_W-1:0]]) begin
        grant[cand[ID_W-1:0]] = 1'b1;
        grant_idx             = cand[ID_W-1:0];
      end
    end
  end

  assign req_ready = grant;
  assign xfer      = |(grant & req_valid);

  // Sign-extended operands; the low PROD_W bits equal the signed product.
  assign prod = {{DIN1_W{s1_a[DIN0_W-1]}}, s1_a} * {{DIN0_W{s1_b[DIN1_W-1]}}, s1_b};

`ifdef CASE_2_MUL_SAT_EN
  localparam logic [DOUT_W-1:0] SAT_MAX = {1'b0, {(DOUT_W-1){1'b1}}};
  localparam logic [DOUT_W-1:0] SAT_MIN = {1'b1, {(DOUT_W-1){1'b0}}};
  logic pos_ovf;
  logic neg_ovf;

  assign pos_ovf   = ~prod[PROD_W-1] & (|prod[PROD_W-2:DOUT_W-1]);
  assign neg_ovf   = prod[PROD_W-1] & ~(&prod[PROD_W-2:DOUT_W-1]);
  assign dout_next = pos_ovf ? SAT_MAX : (neg_ovf ? SAT_MIN : prod[DOUT_W-1:0]);
`else
  logic unused_prod_hi;

  assign dout_next      = prod[DOUT_W-1:0];
  assign unused_prod_hi = ^prod[PROD_W-1:DOUT_W];
`endif

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      rr_ptr <= '0;
      s1_vld <= 1'b0;
      s1_id  <= '0;
      s1_a   <= '0;
      s1_b   <= '0;
    end else if (ap_ce) begin
      s1_vld <= xfer;
      if (xfer) begin
        s1_id  <= grant_idx;
        s1_a   <= req_din0[grant_idx*DIN0_W +: DIN0_W];
        s1_b   <= req_din1[grant_idx*DIN1_W +: DIN1_W];
        rr_ptr <= (grant_idx == LAST_ID) ? '0 : grant_idx + 1'b1;
      end
    end
  end

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      res_vld  <= 1'b0;
      res_id   <= '0;
      res_dout <= '0;
`ifdef CASE_2_MUL_SAT_EN
      sat_flag <= 1'b0;
`endif
    end else if (ap_ce) begin
      res_vld  <= s1_vld;
      res_id   <= s1_id;
      res_dout <= dout_next;
`ifdef CASE_2_MUL_SAT_EN
      sat_flag <= pos_ovf | neg_ovf;
`endif
    end
  end

  assign busy = s1_vld | res_vld;

endmodule

`default_nettype wire

// File: tb/tb_case_2_mul_share_arb.sv
// Table-driven bench for case_2_mul_share_arb plus hand sequences for overflow and mid-cycle reset.
`default_nettype none

module tb_case_2_mul_share_arb;
  localparam int NUM_REQ = 4;
  localparam int ID_W    = 2;
  localparam int DIN0_W  = 11;
  localparam int DIN1_W  = 8;
  localparam int DOUT_W  = 11;
  localparam int NVEC    = 22;

  logic                      ap_clk = 1'b0;
  logic                      ap_rst = 1'b0;
  logic                      ap_ce  = 1'b0;
  logic [NUM_REQ-1:0]        req_valid = '0;
  logic [NUM_REQ-1:0]        req_ready;
  logic [NUM_REQ*DIN0_W-1:0] req_din0 = '0;
  logic [NUM_REQ*DIN1_W-1:0] req_din1 = '0;
  logic                      res_vld;
  logic [ID_W-1:0]           res_id;
  logic [DOUT_W-1:0]         res_dout;
  logic                      busy;
`ifdef CASE_2_MUL_SAT_EN
  logic                      sat_flag;
`endif

  case_2_mul_share_arb #(
    .NUM_REQ(NUM_REQ), .ID_W(ID_W), .DIN0_W(DIN0_W), .DIN1_W(DIN1_W), .DOUT_W(DOUT_W)
  ) dut (
    .ap_clk(ap_clk), .ap_rst(ap_rst), .ap_ce(ap_ce),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_din0(req_din0), .req_din1(req_din1),
    .res_vld(res_vld), .res_id(res_id), .res_dout(res_dout),
`ifdef CASE_2_MUL_SAT_EN
    .sat_flag(sat_flag),
`endif
    .busy(busy)
  );

  always #5 ap_clk = ~ap_clk;

  typedef struct packed {
    logic       ce;
    logic [3:0] valid;
    logic [3:0] ready;
    logic       vld;
    logic [1:0] id;
    logic       bsy;
  } vec_t;

  vec_t tbl [NVEC];
  int checks = 0;
  int errors = 0;
  logic signed [DIN0_W-1:0] op_a [NUM_REQ];
  logic signed [DIN1_W-1:0] op_b [NUM_REQ];
  int   exp_dout [NUM_REQ];
  logic exp_sat  [NUM_REQ];

  function automatic vec_t mk(input logic ce, input logic [3:0] valid, input logic [3:0] ready,
                              input logic vld, input logic [1:0] id, input logic bsy);
    vec_t v;
    v.ce = ce; v.valid = valid; v.ready = ready; v.vld = vld; v.id = id; v.bsy = bsy;
    return v;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic drive(input logic ce, input logic [3:0] v);
    ap_ce     = ce;
    req_valid = v;
    for (int i = 0; i < NUM_REQ; i++) begin
      req_din0[i*DIN0_W +: DIN0_W] = op_a[i];
      req_din1[i*DIN1_W +: DIN1_W] = op_b[i];
    end
  endtask

  task automatic step();
    @(posedge ap_clk);
    #1;
  endtask

  task automatic chk_result(input string name, input int id, input int dout, input logic sat);
    chk({name, " vld"}, int'(res_vld), 1);
    chk({name, " id"}, int'(res_id), id);
    chk({name, " dout"}, int'($signed(res_dout)), dout);
`ifdef CASE_2_MUL_SAT_EN
    chk({name, " sat"}, int'(sat_flag), int'(sat));
`else
    if (sat === 1'bx) $display("unexpected x on sat expectation");
`endif
  endtask

  initial begin
    op_a[0] = 11'sd100;  op_b[0] = -8'sd3;
    op_a[1] = -11'sd200; op_b[1] = 8'sd5;
    op_a[2] = 11'sd7;    op_b[2] = -8'sd128;
    op_a[3] = 11'sd1000; op_b[3] = 8'sd100;
    exp_dout[0] = -300;  exp_sat[0] = 1'b0;
    exp_dout[1] = -1000; exp_sat[1] = 1'b0;
    exp_dout[2] = -896;  exp_sat[2] = 1'b0;
`ifdef CASE_2_MUL_SAT_EN
    exp_dout[3] = 1023;  exp_sat[3] = 1'b1;
`else
    exp_dout[3] = -352;  exp_sat[3] = 1'b0;
`endif

    //             ce    valid    ready    vld   id  busy
    tbl[0]  = mk(1'b1, 4'b0001, 4'b0001, 1'b0, 2'd0, 1'b0);
    tbl[1]  = mk(1'b1, 4'b0000, 4'b0000, 1'b0, 2'd0, 1'b1);
    tbl[2]  = mk(1'b1, 4'b0000, 4'b0000, 1'b1, 2'd0, 1'b1);
    tbl[3]  = mk(1'b1, 4'b0000, 4'b0000, 1'b0, 2'd0, 1'b0);
    tbl[4]  = mk(1'b1, 4'b1001, 4'b1000, 1'b0, 2'd0, 1'b0);
    tbl[5]  = mk(1'b1, 4'b1001, 4'b0001, 1'b0, 2'd0, 1'b1);
    tbl[6]  = mk(1'b1, 4'b1000, 4'b1000, 1'b1, 2'd3, 1'b1);
    tbl[7]  = mk(1'b1, 4'b1111, 4'b0001, 1'b1, 2'd0, 1'b1);
    tbl[8]  = mk(1'b1, 4'b1111, 4'b0010, 1'b1, 2'd3, 1'b1);
    tbl[9]  = mk(1'b1, 4'b1111, 4'b0100, 1'b1, 2'd0, 1'b1);
    tbl[10] = mk(1'b1, 4'b1111, 4'b1000, 1'b1, 2'd1, 1'b1);
    tbl[11] = mk(1'b1, 4'b1111, 4'b0001, 1'b1, 2'd2, 1'b1);
    tbl[12] = mk(1'b1, 4'b1111, 4'b0010, 1'b1, 2'd3, 1'b1);
    tbl[13] = mk(1'b1, 4'b1111, 4'b0100, 1'b1, 2'd0, 1'b1);
    tbl[14] = mk(1'b1, 4'b1111, 4'b1000, 1'b1, 2'd1, 1'b1);
    tbl[15] = mk(1'b0, 4'b1111, 4'b0000, 1'b1, 2'd2, 1'b1);
    tbl[16] = mk(1'b0, 4'b1111, 4'b0000, 1'b1, 2'd2, 1'b1);
    tbl[17] = mk(1'b0, 4'b1111, 4'b0000, 1'b1, 2'd2, 1'b1);
    tbl[18] = mk(1'b1, 4'b1111, 4'b0001, 1'b1, 2'd2, 1'b1);
    tbl[19] = mk(1'b1, 4'b0000, 4'b0000, 1'b1, 2'd3, 1'b1);
    tbl[20] = mk(1'b1, 4'b0000, 4'b0000, 1'b1, 2'd0, 1'b1);
    tbl[21] = mk(1'b1, 4'b0000, 4'b0000, 1'b0, 2'd0, 1'b0);

    drive(1'b1, 4'b0000);
    #2 ap_rst = 1'b1;
    step();
    step();
    chk("reset vld", int'(res_vld), 0);
    chk("reset id", int'(res_id), 0);
    chk("reset dout", int'(res_dout), 0);
    chk("reset busy", int'(busy), 0);
`ifdef CASE_2_MUL_SAT_EN
    chk("reset sat", int'(sat_flag), 0);
`endif
    ap_rst = 1'b0;

    for (int k = 0; k < NVEC; k++) begin
      drive(tbl[k].ce, tbl[k].valid);
      #1;
      chk($sformatf("v%0d ready", k), int'(req_ready), int'(tbl[k].ready));
      chk($sformatf("v%0d busy", k), int'(busy), int'(tbl[k].bsy));
      if (tbl[k].vld) begin
        chk_result($sformatf("v%0d", k), int'(tbl[k].id), exp_dout[tbl[k].id], exp_sat[tbl[k].id]);
      end else begin
        chk($sformatf("v%0d vld", k), int'(res_vld), 0);
      end
      step();
    end

    // Negative overflow: -1024 * 127 lands on -1024 both truncated and saturated.
    op_a[1] = -11'sd1024;
    op_b[1] = 8'sd127;
    drive(1'b1, 4'b0010);
    #1;
    chk("negovf ready", int'(req_ready), 4'b0010);
    step();
    drive(1'b1, 4'b0000);
    step();
    chk_result("negovf", 1, -1024, 1'b1);
    step();

    // Fill both stages (grants 2 then 3), then reset asynchronously mid-cycle.
    drive(1'b1, 4'b1111);
    #1;
    chk("prerst ready", int'(req_ready), 4'b0100);
    step();
    step();
    drive(1'b1, 4'b0000);
    chk("prerst vld", int'(res_vld), 1);
    chk("prerst busy", int'(busy), 1);
    #2 ap_rst = 1'b1;
    #1;
    chk("midrst vld", int'(res_vld), 0);
    chk("midrst busy", int'(busy), 0);
    chk("midrst dout", int'(res_dout), 0);
    step();
    ap_rst = 1'b0;
    drive(1'b1, 4'b1111);
    #1;
    chk("postrst ready", int'(req_ready), 4'b0001);
    drive(1'b1, 4'b0000);
    for (int c = 0; c < 3; c++) begin
      step();
      chk($sformatf("postrst%0d vld", c), int'(res_vld), 0);
      chk($sformatf("postrst%0d busy", c), int'(busy), 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
